// File: rtl/data_memory_mmio.sv
// Data memory with memory-mapped switch inputs and display registers for the CPU load/store path.
// Define DATA_MEMORY_MMIO_DEBOUNCE_EN to build per-channel input debouncers.
module data_memory_mmio #(
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 8,
  parameter int IN_CH           = 2,
  parameter int IN_W            = 7,
  parameter int OUT_CH          = 1,
  parameter int OUT_BASE        = 100,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        write_address,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     read_enable,
  input  logic [ADDR_W-1:0]        read_address,
  output logic [DATA_W-1:0]        read_data,
  output logic                     read_valid,
  input  logic [IN_CH*IN_W-1:0]    switches,
  output logic [OUT_CH*DATA_W-1:0] display_output,
  output logic [OUT_CH-1:0]        display_update
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [IN_CH*IN_W-1:0]    sync1_q, sync2_q, committed;
  logic [OUT_CH*DATA_W-1:0] display_q, display_d;
  logic [OUT_CH-1:0]        update_q, update_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     rvalid_q;
  logic                     ram_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= switches;
      sync2_q <= sync1_q;
    end
  end

`ifdef DATA_MEMORY_MMIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [IN_CH*IN_W-1:0]  cand_q, commit_q;
  logic [IN_CH*CNT_W-1:0] cnt_q;

  // Any change restarts the stability count; the candidate commits only once it has held long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      commit_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int k = 0; k < IN_CH; k++) begin
        if (sync2_q[k*IN_W +: IN_W] != cand_q[k*IN_W +: IN_W]) begin
          cand_q[k*IN_W +: IN_W] <= sync2_q[k*IN_W +: IN_W];
          cnt_q[k*CNT_W +: CNT_W] <= '0;
        end else if (cnt_q[k*CNT_W +: CNT_W] != CNT_MAX) begin
          cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + 1'b1;
        end else begin
          commit_q[k*IN_W +: IN_W] <= cand_q[k*IN_W +: IN_W];
        end
      end
    end
  end

  assign committed = commit_q;
`else
  assign committed = sync2_q;
`endif

  always_comb begin
    ram_we    = write_enable;
    display_d = display_q;
    update_d  = '0;
    for (int k = 0; k < IN_CH; k++) begin
      if (write_address == ADDR_W'(k)) ram_we = 1'b0;
    end
    for (int j = 0; j < OUT_CH; j++) begin
      if (write_address == ADDR_W'(OUT_BASE + j)) begin
        ram_we = 1'b0;
        if (write_enable) begin
          display_d[j*DATA_W +: DATA_W] = write_data;
          update_d[j] = 1'b1;
        end
      end
    end
  end

  // Write-first bypass for RAM and display; input channels win last since they ignore writes.
  always_comb begin
    rdata_d = mem[read_address];
    if (write_enable && (write_address == read_address)) rdata_d = write_data;
    for (int j = 0; j < OUT_CH; j++) begin
      if (read_address == ADDR_W'(OUT_BASE + j)) begin
        if (write_enable && (write_address == read_address)) rdata_d = write_data;
        else rdata_d = display_q[j*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < IN_CH; k++) begin
      if (read_address == ADDR_W'(k)) rdata_d = DATA_W'(committed[k*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[write_address] <= write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_q <= '0;
      update_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      display_q <= display_d;
      update_q  <= update_d;
      rvalid_q  <= read_enable;
      if (read_enable) rdata_q <= rdata_d;
    end
  end

  assign read_data      = rdata_q;
  assign read_valid     = rvalid_q;
  assign display_output = display_q;
  assign display_update = update_q;

endmodule
